mem_arbiter: RTL

Sequential arbiter sharing one single-ported unified memory between the pipeline's instruction-fetch port and MEM-stage data port. Sits between the IF/MEM stages and the memory model: one access in flight at a time, with a req/ack handshake per requester and stall indications that the hazard logic turns into pcWrite/ifidWrite/pipeline freeze. Data accesses have priority, and a streak counter keeps a continuous data stream from starving fetch.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-ported unified memory between the instruction
//             fetch port (IF) and the MEM-stage data port (D). One access is
//             in flight at a time. Data has priority, but a streak counter
//             forces a pending fetch through after MAX_D_STREAK contended data
//             grants.
//  Ports    : clk, rst                          - clock, sync active-high reset
//             if_req/if_addr -> if_ack/if_rdata - fetch handshake
//             d_req/d_we/d_addr/d_wdata
//                            -> d_ack/d_rdata   - data handshake
//             m_en/m_we/m_addr/m_wdata          - memory command (registered)
//             m_rdata/m_valid                   - memory completion
//             if_stall, d_stall, busy           - status for hazard logic
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_valid,
    output logic          if_stall,
    output logic          d_stall,
    output logic          busy
);

    localparam int c_STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = c_STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  r_ownerD;   // 1: data port owns the access in flight
    logic                  r_ownerWe;  // in-flight data access is a write
    logic                  w_ifElig;
    logic                  w_dElig;
    logic                  w_grantD;
    logic                  w_grantIf;
    logic                  w_done;

    // A request seen during its own ack cycle is the one just completed.
    assign w_ifElig = if_req & ~if_ack;
    assign w_dElig  = d_req & ~d_ack;

    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_grantD    = 1'b0;
        w_grantIf   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // Data wins unless fetch is also waiting and has been passed
                // over MAX_D_STREAK times in a row.
                if (w_dElig && !(w_ifElig && (r_streak == c_MAX_STREAK))) begin
                    w_grantD = 1'b1;
                end else if (w_ifElig) begin
                    w_grantIf = 1'b1;
                end
                if (w_grantD || w_grantIf) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                w_nextState = WAIT;
            end
            WAIT: begin
                if (m_valid) begin
                    w_done      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak  <= '0;
            r_ownerD  <= 1'b0;
            r_ownerWe <= 1'b0;
            m_en      <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            // The grant edge is the edge entering ISSUE, so the strobe and
            // write enable are high for exactly the ISSUE cycle.
            m_en   <= w_grantD | w_grantIf;
            m_we   <= w_grantD & d_we;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;

            if (w_grantD) begin
                // Only contended data grants count toward the streak.
                if (w_ifElig) begin
                    r_streak <= r_streak + c_STREAK_W'(1);
                end
                r_ownerD  <= 1'b1;
                r_ownerWe <= d_we;
                m_addr    <= d_addr;
                m_wdata   <= d_wdata;
            end else if (w_grantIf) begin
                r_streak  <= '0;
                r_ownerD  <= 1'b0;
                r_ownerWe <= 1'b0;
                m_addr    <= if_addr;
            end

            if (w_done) begin
                if (r_ownerD) begin
                    d_ack <= 1'b1;
                    if (!r_ownerWe) begin
                        d_rdata <= m_rdata;
                    end
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= m_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire
